// File: rtl/div_unit_pkg.sv
// Shared definitions for the iterative divider.
//   DivWidth       default operand/result width
//   div_state_e    FSM encoding (DIV_IDLE / DIV_BUSY / DIV_DONE)
//   div_cnt_width  width of the iteration counter for a given operand width
package div_unit_pkg;

  localparam int unsigned DivWidth = 32;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  function automatic int unsigned div_cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/div_unit_step.sv
// One radix-2 restoring-division iteration, purely combinational.
// Kept separate so several instances can later be chained for radix-4.
//   rem_i  partial remainder (always < dvs_i on entry)
//   quo_i  dividend/quotient shift register
//   dvs_i  divisor magnitude
//   rem_o  next partial remainder
//   quo_o  next quotient shift register (new quotient bit in bit 0)
module div_step import div_unit_pkg::*; #(
  parameter int unsigned WIDTH = DivWidth
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] dvs_ext;
  logic [WIDTH:0] rem_nxt;
  logic           no_borrow;
  logic           unused_rem_msb;

  always_comb begin
    rem_sh    = {rem_i, quo_i[WIDTH-1]};
    dvs_ext   = {1'b0, dvs_i};
    no_borrow = (rem_sh >= dvs_ext);
    rem_nxt   = no_borrow ? (rem_sh - dvs_ext) : rem_sh;
    // rem_i < dvs_i on entry, so the result always fits in WIDTH bits.
    rem_o     = rem_nxt[WIDTH-1:0];
    quo_o     = {quo_i[WIDTH-2:0], no_borrow};
  end

  assign unused_rem_msb = rem_nxt[WIDTH];

endmodule

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider (DIV / DIVU) beside the execute-stage ALU.
// Optional feature: define DIV_ZERO_FAST_EN to skip the iterations for a zero
// divisor (result ready one cycle after accept, same values as the slow path).
//   clk, reset            clock, synchronous active-high reset
//   div_valid/div_ready   operation request handshake (ready only in IDLE)
//   div_signed            1 = DIV (two's complement), 0 = DIVU
//   div_src1, div_src2    dividend, divisor (sampled at accept only)
//   flush                 cancel current operation, highest priority
//   res_valid/res_ready   result handshake
//   res_hi, res_lo        remainder, quotient (registered, held in DONE)
//   busy                  state != IDLE
module div_unit import div_unit_pkg::*; #(
  parameter int unsigned WIDTH = DivWidth
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             div_valid,
  output logic             div_ready,
  input  logic             div_signed,
  input  logic [WIDTH-1:0] div_src1,
  input  logic [WIDTH-1:0] div_src2,
  input  logic             flush,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo,
  output logic             busy
);

  localparam int unsigned CntW = div_cnt_width(WIDTH);

  div_state_e       state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic [WIDTH-1:0] res_hi_q, res_hi_d;
  logic [WIDTH-1:0] res_lo_q, res_lo_d;
  logic             res_valid_q, res_valid_d;

  logic [WIDTH-1:0] step_rem, step_quo;
  logic [WIDTH-1:0] abs1, abs2;
  logic             q_neg_in, r_neg_in;
  logic             accept;

  function automatic logic [WIDTH-1:0] sign_fix(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem_i(rem_q),
    .quo_i(quo_q),
    .dvs_i(dvs_q),
    .rem_o(step_rem),
    .quo_o(step_quo)
  );

  assign div_ready = (state_q == DIV_IDLE) & ~flush;
  assign busy      = (state_q != DIV_IDLE);
  // Gated so no result handshake can complete in a flush cycle.
  assign res_valid = res_valid_q & ~flush;
  assign res_hi    = res_hi_q;
  assign res_lo    = res_lo_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    q_neg_d     = q_neg_q;
    r_neg_d     = r_neg_q;
    res_hi_d    = res_hi_q;
    res_lo_d    = res_lo_q;
    res_valid_d = res_valid_q;

    accept   = div_valid & div_ready;
    // Magnitudes wrap at WIDTH bits: |0x80..0| stays 0x80..0, which gives
    // the architected overflow result without a special case.
    abs1     = sign_fix(div_src1, div_signed & div_src1[WIDTH-1]);
    abs2     = sign_fix(div_src2, div_signed & div_src2[WIDTH-1]);
    q_neg_in = div_signed & (div_src1[WIDTH-1] ^ div_src2[WIDTH-1]);
    r_neg_in = div_signed & div_src1[WIDTH-1];

    unique case (state_q)
      DIV_IDLE: begin
        if (accept) begin
          rem_d   = '0;
          quo_d   = abs1;
          dvs_d   = abs2;
          q_neg_d = q_neg_in;
          r_neg_d = r_neg_in;
          cnt_d   = '0;
          state_d = DIV_BUSY;
`ifdef DIV_ZERO_FAST_EN
          if (div_src2 == '0) begin
            state_d     = DIV_DONE;
            res_lo_d    = sign_fix('1, q_neg_in);
            // Sign-fixed |src1| is src1 itself.
            res_hi_d    = div_src1;
            res_valid_d = 1'b1;
          end
`endif
        end
      end
      DIV_BUSY: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(WIDTH - 1)) begin
          state_d     = DIV_DONE;
          res_lo_d    = sign_fix(step_quo, q_neg_q);
          res_hi_d    = sign_fix(step_rem, r_neg_q);
          res_valid_d = 1'b1;
        end
      end
      DIV_DONE: begin
        if (res_valid & res_ready) begin
          state_d     = DIV_IDLE;
          res_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = DIV_IDLE;
        res_valid_d = 1'b0;
      end
    endcase

    if (flush) begin
      state_d     = DIV_IDLE;
      res_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= DIV_IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      res_hi_q    <= '0;
      res_lo_q    <= '0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      q_neg_q     <= q_neg_d;
      r_neg_q     <= r_neg_d;
      res_hi_q    <= res_hi_d;
      res_lo_q    <= res_lo_d;
      res_valid_q <= res_valid_d;
    end
  end

endmodule
